seg7_out_display: RTL

- Consumer end of the processor's 16-bit `out` bus.
- Takes the 16-bit word and shows it as four hexadecimal digits on a multiplexed, common-anode 7-segment display.
- Sits at the top level between the processor wrapper and the board pins.
- Captures a new word on request, applies it only at frame boundaries so digits never tear, scans the digits with a programmable refresh rate, and inserts blanking to prevent ghosting.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_hex_decoder.sv | 11 +
 rtl/seg7_out_display.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment output display: hex glyph table,
// the all-segments-off constant, the digit index type and the leading-zero rule.
package seg7_pkg;

    typedef logic [1:0] dig_idx_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Active-high {g,f,e,d,c,b,a} glyphs for 0..F
    localparam logic [6:0] HEX_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Digit idx is blanked when it and every more-significant nibble are zero
    function automatic logic lz_blank(input logic [15:0] word, input dig_idx_t idx,
                                      input logic en);
        logic v;
        case (idx)
            2'd1:    v = (word[15:4] == 12'h000);
            2'd2:    v = (word[15:8] == 8'h00);
            2'd3:    v = (word[15:12] == 4'h0);
            default: v = 1'b0;
        endcase
        return en & v;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-high 7-segment glyph lookup.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_TABLE[i_nib];

endmodule

// File: rtl/seg7_out_display.sv
// Four-digit multiplexed hex display: frame-synchronous word update, per-slot
// anode blanking, optional leading-zero suppression and selectable polarity.
module seg7_out_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int              CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]      POL_AN    = {4{ACTIVE_LOW}};
    localparam logic [6:0]      POL_SEG   = {7{ACTIVE_LOW}};

    logic [CNT_W-1:0] r_div_cnt;
    dig_idx_t         r_dig_idx;
    logic [15:0]      r_pending;
    logic             r_pending_vld;
    logic [15:0]      r_shadow;
    logic             r_frame_tick;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;
    logic             r_dp;

    logic             w_wrap;
    logic             w_boundary;
    logic             w_update;
    logic [3:0]       w_nib;
    logic [6:0]       w_hex;
    logic             w_lz;
    logic [3:0]       w_an_log;
    logic [6:0]       w_seg_log;
    logic             w_dp_log;

    assign w_wrap     = (r_div_cnt == CNT_LAST);
    assign w_boundary = w_wrap & (r_dig_idx == 2'd3);
    assign w_update   = w_boundary & r_pending_vld;
    assign w_nib      = r_shadow[{r_dig_idx, 2'b00} +: 4];
    assign w_lz       = lz_blank(r_shadow, r_dig_idx, blank_lz);

    seg7_hex_decoder u_dec (
        .i_nib (w_nib),
        .o_seg (w_hex)
    );

    // Slot timer and digit scan pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_dig_idx <= 2'd0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            r_dig_idx <= r_dig_idx + 2'd1;
        end else begin
            r_div_cnt <= r_div_cnt + CNT_ONE;
        end
    end

    // Pending capture and frame-boundary transfer; a load on the boundary
    // edge refills pending while the older word moves to the shadow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending     <= 16'h0000;
            r_pending_vld <= 1'b0;
            r_shadow      <= 16'h0000;
            r_frame_tick  <= 1'b0;
        end else begin
            r_frame_tick <= w_update;
            if (w_update) begin
                r_shadow <= r_pending;
            end
            if (load) begin
                r_pending     <= data_in;
                r_pending_vld <= 1'b1;
            end else if (w_update) begin
                r_pending_vld <= 1'b0;
            end
        end
    end

    // Logical (active-high) drive for the current slot
    always_comb begin
        w_an_log  = 4'h0;
        w_seg_log = SEG_OFF;
        w_dp_log  = 1'b0;
        if (r_div_cnt < CNT_BLANK) begin
            w_an_log  = 4'h0;
            w_seg_log = SEG_OFF;
            w_dp_log  = 1'b0;
        end else begin
            w_an_log  = 4'b0001 << r_dig_idx;
            w_seg_log = w_lz ? SEG_OFF : w_hex;
            w_dp_log  = dp_in[r_dig_idx];
        end
    end

    // Output registers with polarity applied; reset forces the dark level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= POL_AN;
            r_seg <= POL_SEG;
            r_dp  <= ACTIVE_LOW;
        end else begin
            r_an  <= w_an_log ^ POL_AN;
            r_seg <= w_seg_log ^ POL_SEG;
            r_dp  <= w_dp_log ^ ACTIVE_LOW;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule
